// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared definitions for the BRAM FIFO controller slice.
// Provides default geometry, the output-buffer occupancy type, and the
// read-issue room check that is shared between the top and the buffer.
package bram_fifo_ctrl_pkg;

  localparam int DEF_ABITS = 8;
  localparam int DEF_DBITS = 8;

  // Output buffer holds 0..2 words
  typedef logic [1:0] buf_cnt_t;

  // True when the output buffer can accept one more word after this cycle's
  // pop and any read already in flight. A pop never happens on an empty
  // buffer, so the subtraction cannot underflow.
  function automatic logic room_after_pop(buf_cnt_t buf_cnt, logic inflight, logic pop);
    logic [2:0] occ;
    occ = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    return occ < 3'd2;
  endfunction

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for bram_fifo_ctrl.
// Ports: input stream (in_valid/in_ready/in_data), output stream
// (out_valid/out_ready/out_data), RAM write port, RAM read port, occupancy.
// slave  = the controller's view, master = the environment's view.
interface bram_fifo_ctrl_if
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int ABITS = DEF_ABITS,
  parameter int DBITS = DEF_DBITS
);
  logic             in_valid;
  logic             in_ready;
  logic [DBITS-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DBITS-1:0] out_data;
  logic             mem_wr_en;
  logic [ABITS-1:0] mem_wr_addr;
  logic [DBITS-1:0] mem_wr_data;
  logic [ABITS-1:0] mem_rd_addr;
  logic [DBITS-1:0] mem_rd_data;
  logic [ABITS+1:0] count;

  modport slave (
    input  in_valid, in_data, out_ready, mem_rd_data,
    output in_ready, out_valid, out_data,
           mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr, count
  );

  modport master (
    output in_valid, in_data, out_ready, mem_rd_data,
    input  in_ready, out_valid, out_data,
           mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr, count
  );
endinterface

// File: rtl/bram_fifo_outbuf.sv
// Two-entry capture/pop buffer behind the RAM read port.
// Ports: clk, rst; cap_i/cap_data_i capture a RAM read word at the tail;
// pop_i removes the head; head_o/valid_o present the head; buf_count_o is
// the occupancy (0..2). Storage is not reset, only the occupancy.
module bram_fifo_outbuf
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int DBITS = DEF_DBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_i,
  input  logic [DBITS-1:0] cap_data_i,
  input  logic             pop_i,
  output logic [DBITS-1:0] head_o,
  output logic             valid_o,
  output buf_cnt_t         buf_count_o
);

  logic [DBITS-1:0] e0_q, e0_d, e1_q, e1_d;
  buf_cnt_t         cnt_q, cnt_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (cap_i) begin
          e0_d  = cap_data_i;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (cap_i && pop_i) begin
          e0_d = cap_data_i;
        end else if (cap_i) begin
          e1_d  = cap_data_i;
          cnt_d = 2'd2;
        end else if (pop_i) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        // Capture without pop cannot occur here: reads stop at two words
        if (pop_i) begin
          e0_d = e1_q;
          if (cap_i) e1_d  = cap_data_i;
          else       cnt_d = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 2'd0;
    else     cnt_q <= cnt_d;
  end

  assign head_o      = e0_q;
  assign valid_o     = (cnt_q != 2'd0);
  assign buf_count_o = cnt_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Stream-to-BRAM FIFO controller in front of a simple dual-port RAM with a
// registered, non-transparent, 1-cycle read port.
// Ports: clk, rst (sync, active-high); bus (slave) carries the input stream,
// output stream, RAM write port, RAM read port and total occupancy count.
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int ABITS = DEF_ABITS,
  parameter int DBITS = DEF_DBITS
) (
  input  logic           clk,
  input  logic           rst,
  bram_fifo_ctrl_if.slave bus
);

  localparam int               DEPTH     = 2 ** ABITS;
  localparam logic [ABITS:0]   DEPTH_CNT = {1'b1, {ABITS{1'b0}}};
  localparam logic [ABITS-1:0] PTR_ONE   = {{(ABITS-1){1'b0}}, 1'b1};
  localparam logic [ABITS:0]   CNT_ONE   = {{ABITS{1'b0}}, 1'b1};

  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ABITS:0]   mem_count_q, mem_count_d;
  logic             inflight_q, inflight_d;
  logic             push, pop, rd_issue;
  buf_cnt_t         buf_count;
  logic             buf_valid;
  logic [DBITS-1:0] buf_head;

  assign bus.in_ready = !rst && (mem_count_q != DEPTH_CNT);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = buf_valid && bus.out_ready;

  // mem_count only covers words already written, so a word pushed this
  // cycle is never read at the address being written this cycle.
  assign rd_issue = (mem_count_q != '0) && room_after_pop(buf_count, inflight_q, pop);

  always_comb begin
    wr_ptr_d    = push     ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = rd_issue ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    inflight_d  = rd_issue;
    mem_count_d = mem_count_q;
    case ({push, rd_issue})
      2'b10:   mem_count_d = mem_count_q + CNT_ONE;
      2'b01:   mem_count_d = mem_count_q - CNT_ONE;
      default: mem_count_d = mem_count_q;
    endcase
  end

  // Stage boundary: RAM address issue -> RAM data return
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      inflight_q  <= inflight_d;
    end
  end

  // Stage boundary: RAM data return -> output buffer
  bram_fifo_outbuf #(.DBITS(DBITS)) u_outbuf (
    .clk        (clk),
    .rst        (rst),
    .cap_i      (inflight_q),
    .cap_data_i (bus.mem_rd_data),
    .pop_i      (pop),
    .head_o     (buf_head),
    .valid_o    (buf_valid),
    .buf_count_o(buf_count)
  );

  assign bus.mem_wr_en   = push;
  assign bus.mem_wr_addr = wr_ptr_q;
  assign bus.mem_wr_data = bus.in_data;
  assign bus.mem_rd_addr = rd_ptr_q;
  assign bus.out_valid   = buf_valid;
  assign bus.out_data    = buf_head;
  assign bus.count       = {1'b0, mem_count_q}
                         + {{(ABITS+1){1'b0}}, inflight_q}
                         + {{ABITS{1'b0}}, buf_count};

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: behavioural RAM, queue reference model.
module tb_bram_fifo_ctrl;
  import bram_fifo_ctrl_pkg::*;

  localparam int ABITS = 8;
  localparam int DBITS = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_fifo_ctrl_if #(.ABITS(ABITS), .DBITS(DBITS)) bus ();

  bram_fifo_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Simple dual-port RAM: registered read returns the old contents on a
  // same-address write, so a read-during-write hazard corrupts the data.
  logic [DBITS-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_wr_en) ram[bus.mem_wr_addr] <= bus.mem_wr_data;
    bus.mem_rd_data <= ram[bus.mem_rd_addr];
  end

  // Reference model: FIFO of accepted words; occupancy is pushes - pops.
  logic [DBITS-1:0] mq[$];
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      chk("count", 32'(bus.count), 32'(mq.size()));
      if (32'(bus.count) <= DEPTH - 1) chk("in_ready_open", 32'(bus.in_ready), 32'd1);
      if (32'(bus.count) == DEPTH + 2) chk("in_ready_full", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        chk("pop_nonempty", 32'(mq.size() != 0), 32'd1);
        if (mq.size() != 0) chk("out_data", 32'(bus.out_data), 32'(mq.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) mq.push_back(bus.in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
  endtask

  task automatic fill(output int acc);
    acc = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      #1;
      if (!bus.in_ready) break;
      acc++;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(string tag);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 600 && bus.count != 0; c++) tick();
    tick();
    chk(tag, 32'(bus.count), 32'd0);
  endtask

  initial begin
    int first, last, npop, acc;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Single word latency
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    #1;
    chk("t1_wr_en", 32'(bus.mem_wr_en), 32'd1);
    chk("t1_wr_addr", 32'(bus.mem_wr_addr), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("t1_valid_e0", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t1_valid_e1", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t1_valid_e2", 32'(bus.out_valid), 32'd1);
    chk("t1_data", 32'(bus.out_data), 32'h11);
    tick();
    chk("t1_count", 32'(bus.count), 32'd0);

    // 300 words streaming, pointers wrap, no bubbles
    do_reset();
    bus.out_ready = 1'b1;
    first = -1; last = -1; npop = 0;
    for (int c = 0; c < 400; c++) begin
      if (c < 300) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(c);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c < 300) begin
        chk("t2_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t2_wr_addr", 32'(bus.mem_wr_addr), 32'(c % 256));
      end
      if (bus.out_valid) begin
        if (first < 0) first = c;
        last = c;
        npop++;
      end
      tick();
    end
    chk("t2_pops", 32'(npop), 32'd300);
    chk("t2_span", 32'(last - first), 32'd299);

    // Fill to capacity, then drain
    do_reset();
    fill(acc);
    chk("t3_accepted", 32'(acc), 32'd258);
    chk("t3_count", 32'(bus.count), 32'd258);
    drain("t3_drain");

    // Full, single pop reopens input one cycle later
    do_reset();
    fill(acc);
    chk("t4_accepted", 32'(acc), 32'd258);
    bus.out_ready = 1'b1;
    #1;
    chk("t4_closed", 32'(bus.in_ready), 32'd0);
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("t4_reopen", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("t4_count", 32'(bus.count), 32'd258);
    chk("t4_closed_again", 32'(bus.in_ready), 32'd0);
    drain("t4_drain");

    // From empty, push every cycle with random consumer
    do_reset();
    acc = 0;
    for (int c = 0; c < 200; c++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t5_accepted", 32'(acc), 32'd200);
    drain("t5_drain");

    // Reset with a read in flight discards everything
    do_reset();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_count", 32'(bus.count), 32'd0);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 8 && !bus.out_valid; c++) tick();
    chk("t6_first_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_first_data", 32'(bus.out_data), 32'hA5);
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
